// File: rtl/rvv_backend_dispatch_opr_stage_pkg.sv
// rvv_backend_dispatch_opr_stage_pkg: shared widths, source ids, stall-count type and saturating increment
package rvv_backend_dispatch_opr_stage_pkg;
  localparam int VLEN = 128;
  localparam int ROB_DEPTH_DEF = 8;
  localparam int VREG_W_DEF = 5;
  localparam int STALL_W = 8;
  localparam int NSRC = 4;
  typedef enum logic [1:0] {SRC_VS1, SRC_VS2, SRC_VD, SRC_V0} src_e;
  typedef logic [STALL_W-1:0] stall_cnt_t;
  function automatic stall_cnt_t sat_inc(stall_cnt_t c);
    return (&c) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/rvv_backend_dispatch_opr_stage_if.sv
// rvv_backend_dispatch_opr_stage_if: issue-slot valid/ready bus with resolved operands
interface rvv_backend_dispatch_opr_stage_if
  import rvv_backend_dispatch_opr_stage_pkg::*;
#(
  parameter int DATA_W = VLEN
);
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_vs1_data;
  logic [DATA_W-1:0] issue_vs2_data;
  logic [DATA_W-1:0] issue_vd_data;
  logic [DATA_W-1:0] issue_v0_data;
  stall_cnt_t        issue_stall_cnt;
  modport master (
    output issue_valid, issue_vs1_data, issue_vs2_data, issue_vd_data, issue_v0_data, issue_stall_cnt,
    input  issue_ready
  );
  modport slave (
    input  issue_valid, issue_vs1_data, issue_vs2_data, issue_vd_data, issue_v0_data, issue_stall_cnt,
    output issue_ready
  );
endinterface

// File: rtl/rvv_backend_dispatch_youngest_sel.sv
// rvv_backend_dispatch_youngest_sel: one-hot of the hit entry with the largest age relative to the ROB head
module rvv_backend_dispatch_youngest_sel #(
  parameter int ROB_DEPTH = 8,
  parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic [ROB_DEPTH-1:0] hit,
  input  logic [IDX_W-1:0]     head,
  output logic [ROB_DEPTH-1:0] onehot,
  output logic                 any
);
  logic [IDX_W-1:0] age;
  logic [IDX_W-1:0] best_age;
  logic [IDX_W-1:0] best_idx;
  always_comb begin
    age      = '0;
    best_age = '0;
    best_idx = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      age = IDX_W'(i) - head;
      if (hit[i] && age >= best_age) begin
        best_age = age;
        best_idx = IDX_W'(i);
      end
    end
  end
  assign any    = |hit;
  assign onehot = any ? ROB_DEPTH'(1) << best_idx : '0;
endmodule

// File: rtl/rvv_backend_dispatch_opr_stage.sv
// rvv_backend_dispatch_opr_stage: check slot feeding the RAW checker, operand resolve, registered issue slot
module rvv_backend_dispatch_opr_stage
  import rvv_backend_dispatch_opr_stage_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int IDX_W     = $clog2(ROB_DEPTH),
  parameter int DATA_W    = VLEN,
  parameter int VREG_W    = VREG_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             trap_flush_rvv,
  input  logic                             uop_valid,
  output logic                             uop_ready,
  input  logic [VREG_W-1:0]                uop_vs1_index,
  input  logic [VREG_W-1:0]                uop_vs2_index,
  input  logic [VREG_W-1:0]                uop_vd_index,
  input  logic                             uop_vs1_valid,
  input  logic                             uop_vs2_valid,
  input  logic                             uop_vs3_valid,
  input  logic                             uop_vm,
  output logic [VREG_W-1:0]                chk_vs1_index,
  output logic [VREG_W-1:0]                chk_vs2_index,
  output logic [VREG_W-1:0]                chk_vd_index,
  output logic                             chk_vs1_valid,
  output logic                             chk_vs2_valid,
  output logic                             chk_vs3_valid,
  output logic                             chk_vm,
  input  logic [ROB_DEPTH-1:0]             raw_vs1_hit,
  input  logic [ROB_DEPTH-1:0]             raw_vs2_hit,
  input  logic [ROB_DEPTH-1:0]             raw_vd_hit,
  input  logic [ROB_DEPTH-1:0]             raw_v0_hit,
  input  logic                             raw_vs1_wait,
  input  logic                             raw_vs2_wait,
  input  logic                             raw_vd_wait,
  input  logic                             raw_v0_wait,
  input  logic [IDX_W-1:0]                 rob_head_ptr,
  input  logic [ROB_DEPTH-1:0][DATA_W-1:0] rob_w_data,
  input  logic [DATA_W-1:0]                vrf_vs1_data,
  input  logic [DATA_W-1:0]                vrf_vs2_data,
  input  logic [DATA_W-1:0]                vrf_vd_data,
  input  logic [DATA_W-1:0]                vrf_v0_data,
  rvv_backend_dispatch_opr_stage_if.master iss
);
  localparam int UOP_W = 3 * VREG_W + 4;
  logic                         chk_valid_q, chk_valid_d;
  logic [UOP_W-1:0]             uop_q, uop_d;
  stall_cnt_t                   chk_stall_q, chk_stall_d;
  logic                         issue_valid_q, issue_valid_d;
  logic [NSRC-1:0][DATA_W-1:0]  opr_q, opr_d;
  stall_cnt_t                   issue_stall_q, issue_stall_d;
  logic                         f_vs1_valid, f_vs2_valid, f_vs3_valid, f_vm;
  logic                         resolve, issue_free, move, accept;
  logic [NSRC-1:0][ROB_DEPTH-1:0] hit;
  logic [NSRC-1:0][DATA_W-1:0]  vrf, opr;
  logic [NSRC-1:0]              need;
  logic [ROB_DEPTH-1:0]         oh [NSRC];
  logic                         any [NSRC];
  logic [DATA_W-1:0]            sel;
  assign {chk_vs1_index, chk_vs2_index, chk_vd_index, f_vs1_valid, f_vs2_valid, f_vs3_valid, f_vm} = uop_q;
  assign chk_vs1_valid = chk_valid_q & f_vs1_valid;
  assign chk_vs2_valid = chk_valid_q & f_vs2_valid;
  assign chk_vs3_valid = chk_valid_q & f_vs3_valid;
  assign chk_vm        = ~chk_valid_q | f_vm;
  assign hit  = {raw_v0_hit, raw_vd_hit, raw_vs2_hit, raw_vs1_hit};
  assign vrf  = {vrf_v0_data, vrf_vd_data, vrf_vs2_data, vrf_vs1_data};
  assign need = {~f_vm, f_vs3_valid, f_vs2_valid, f_vs1_valid};
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    rvv_backend_dispatch_youngest_sel #(
      .ROB_DEPTH (ROB_DEPTH),
      .IDX_W     (IDX_W)
    ) u_sel (
      .hit    (hit[s]),
      .head   (rob_head_ptr),
      .onehot (oh[s]),
      .any    (any[s])
    );
  end
  always_comb begin
    sel = '0;
    opr = '0;
    for (int s = 0; s < NSRC; s++) begin
      sel = '0;
      for (int i = 0; i < ROB_DEPTH; i++) sel = sel | (oh[s][i] ? rob_w_data[i] : '0);
      opr[s] = ~need[s] ? '0 : any[s] ? sel : vrf[s];
    end
  end
  always_comb begin
    resolve       = chk_valid_q & ~(raw_vs1_wait | raw_vs2_wait | raw_vd_wait | raw_v0_wait);
    issue_free    = ~issue_valid_q | iss.issue_ready;
    move          = resolve & issue_free;
    uop_ready     = ~trap_flush_rvv & (~chk_valid_q | move);
    accept        = uop_valid & uop_ready;
    chk_valid_d   = ~trap_flush_rvv & (accept | (chk_valid_q & ~move));
    uop_d         = accept ? {uop_vs1_index, uop_vs2_index, uop_vd_index,
                              uop_vs1_valid, uop_vs2_valid, uop_vs3_valid, uop_vm} : uop_q;
    chk_stall_d   = (trap_flush_rvv | accept | move) ? '0 :
                    (chk_valid_q & ~resolve) ? sat_inc(chk_stall_q) : chk_stall_q;
    issue_valid_d = ~trap_flush_rvv & (move | (issue_valid_q & ~iss.issue_ready));
    opr_d         = trap_flush_rvv ? '0 : move ? opr : opr_q;
    issue_stall_d = trap_flush_rvv ? '0 : move ? chk_stall_q : issue_stall_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid_q   <= 1'b0;
      uop_q         <= '0;
      chk_stall_q   <= '0;
      issue_valid_q <= 1'b0;
      opr_q         <= '0;
      issue_stall_q <= '0;
    end else begin
      chk_valid_q   <= chk_valid_d;
      uop_q         <= uop_d;
      chk_stall_q   <= chk_stall_d;
      issue_valid_q <= issue_valid_d;
      opr_q         <= opr_d;
      issue_stall_q <= issue_stall_d;
    end
  end
  assign iss.issue_valid     = issue_valid_q;
  assign iss.issue_vs1_data  = opr_q[SRC_VS1];
  assign iss.issue_vs2_data  = opr_q[SRC_VS2];
  assign iss.issue_vd_data   = opr_q[SRC_VD];
  assign iss.issue_v0_data   = opr_q[SRC_V0];
  assign iss.issue_stall_cnt = issue_stall_q;
endmodule
